// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - fetch-to-dispatch circular instruction queue with one-cycle flush; optional INSTR_QUEUE_BYPASS_EN zero-latency bypass
module instr_queue #(
   parameter int DEPTH   = 4,
   parameter int INSTR_W = 32,
   parameter int PC_W    = 32
) (
   input  logic                         CLK,
   input  logic                         nrst,
   input  logic                         fetch_valid,
   input  logic [INSTR_W-1:0]           instr_in,
   input  logic [PC_W-1:0]              pc_in,
   output logic                         fetch_ready,
   output logic                         disp_valid,
   output logic [INSTR_W-1:0]           instr_out,
   output logic [PC_W-1:0]              pc_out,
   input  logic                         disp_ready,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

   logic [INSTR_W-1:0] instr_mem_q [DEPTH];
   logic [PC_W-1:0]    pc_mem_q    [DEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic stored_valid;
   logic bypass;
   logic push;
   logic pop;

   assign stored_valid = (count_q != '0);

   // Full queue refuses fetch even when dispatch pops this cycle, keeping ready off the pop path.
   assign fetch_ready = nrst && (count_q != FULL);

`ifdef INSTR_QUEUE_BYPASS_EN
   // Empty queue with a waiting consumer hands the fetched entry straight through.
   assign bypass    = nrst && !stored_valid && fetch_valid && disp_ready && !flush;
   assign instr_out = bypass ? instr_in : instr_mem_q[head_q];
   assign pc_out    = bypass ? pc_in    : pc_mem_q[head_q];
`else
   assign bypass    = 1'b0;
   assign instr_out = instr_mem_q[head_q];
   assign pc_out    = pc_mem_q[head_q];
`endif

   assign disp_valid = nrst && (stored_valid || bypass);
   assign push       = fetch_valid && fetch_ready && !flush && !bypass;
   assign pop        = nrst && stored_valid && disp_ready && !flush;
   assign count      = count_q;

   // Pointer and occupancy next state; flush wins over any same-cycle push or pop.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
         if (pop)  head_d = (head_q == LAST) ? '0 : head_q + 1'b1;
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Pointer and count registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!nrst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage is written at the tail on push; contents need no reset since count gates validity.
   always_ff @(posedge CLK) begin
      if (push) begin
         instr_mem_q[tail_q] <= instr_in;
         pc_mem_q[tail_q]    <= pc_in;
      end
   end

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - randomized and directed bench for instr_queue against a queue-based model
module tb_instr_queue;

   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        nrst;
   logic        fetch_valid;
   logic [31:0] instr_in;
   logic [31:0] pc_in;
   logic        fetch_ready;
   logic        disp_valid;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        disp_ready;
   logic        flush;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;
   bit accepted;

   // model state: entries as {instr, pc}, front is the head
   logic [63:0] mq[$];

   instr_queue #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(32)) dut (
      .CLK(CLK), .nrst(nrst), .fetch_valid(fetch_valid), .instr_in(instr_in),
      .pc_in(pc_in), .fetch_ready(fetch_ready), .disp_valid(disp_valid),
      .instr_out(instr_out), .pc_out(pc_out), .disp_ready(disp_ready),
      .flush(flush), .count(count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_byp();
`ifdef INSTR_QUEUE_BYPASS_EN
      return nrst && mq.size() == 0 && fetch_valid && disp_ready && !flush;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_update();
      bit byp, fr, do_pop, do_push;
      accepted = 0;
      if (!nrst || flush) begin
         mq.delete();
      end else begin
         byp     = m_byp();
         fr      = (mq.size() != DEPTH);
         do_pop  = !byp && mq.size() != 0 && disp_ready;
         do_push = fetch_valid && fr && !byp;
         if (byp) accepted = 1;
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            mq.push_back({instr_in, pc_in});
            accepted = 1;
         end
      end
   endtask

   task automatic step();
      @(posedge CLK);
      model_update();
      #1;
   endtask

   task automatic push_one(input logic [31:0] pc);
      fetch_valid = 1'b1;
      pc_in       = pc;
      instr_in    = $urandom;
      step();
      fetch_valid = 1'b0;
   endtask

   // compare every cycle, mid-low phase, against the model
   always @(negedge CLK) begin
      if (chk_en) begin
         bit byp, exp_dv;
         byp    = m_byp();
         exp_dv = nrst && (mq.size() != 0 || byp);
         chk("fetch_ready", fetch_ready, nrst && mq.size() != DEPTH);
         chk("disp_valid", disp_valid, exp_dv);
         if (nrst) chk("count", count, mq.size());
         if (exp_dv) begin
            if (byp) begin
               chk("pc_out_bypass", pc_out, pc_in);
               chk("instr_out_bypass", instr_out, instr_in);
            end else begin
               chk("pc_out", pc_out, mq[0][31:0]);
               chk("instr_out", instr_out, mq[0][63:32]);
            end
         end
      end
   end

   initial begin
      nrst = 1'b0; fetch_valid = 1'b1; instr_in = 32'hdead_beef; pc_in = 32'h999;
      disp_ready = 1'b0; flush = 1'b0;

      // reset held with fetch_valid high
      step();
      chk_en = 1;
      step();
      #5;
      chk("rst_count", count, 0);
      chk("rst_disp_valid", disp_valid, 0);
      chk("rst_fetch_ready", fetch_ready, 0);
      step();
      nrst = 1'b1; fetch_valid = 1'b0;
      #5;
      chk("post_rst_fetch_ready", fetch_ready, 1);
      chk("post_rst_disp_valid", disp_valid, 0);

      // fill to DEPTH, fifth push refused
      step();
      for (int k = 0; k < 4; k++) push_one(32'(k * 4));
      fetch_valid = 1'b1; pc_in = 32'h10;
      #5;
      chk("full_count", count, 4);
      chk("full_fetch_ready", fetch_ready, 0);
      step();
      fetch_valid = 1'b0;
      #5;
      chk("refused_count", count, 4);

      // drain in order
      step();
      disp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #5;
         chk("drain_pc", pc_out, 32'(k * 4));
         step();
      end
      #5;
      chk("drained_valid", disp_valid, 0);

      // simultaneous push/pop at count 2
      step();
      disp_ready = 1'b0;
      push_one(32'h10);
      push_one(32'h14);
      fetch_valid = 1'b1; pc_in = 32'h18; disp_ready = 1'b1;
      #5;
      chk("pp_head_before", pc_out, 32'h10);
      step();
      fetch_valid = 1'b0; disp_ready = 1'b0;
      #5;
      chk("pp_count", count, 2);
      chk("pp_head_after", pc_out, 32'h14);

      // full with pop pending
      step();
      push_one(32'h1C);
      push_one(32'h20);
      fetch_valid = 1'b1; pc_in = 32'h24; disp_ready = 1'b1;
      #5;
      chk("full_pop_ready", fetch_ready, 0);
      step();
      disp_ready = 1'b0;
      #5;
      chk("full_pop_count", count, 3);

      // flush with fetch_valid high
      step();
      flush = 1'b1; fetch_valid = 1'b1; pc_in = 32'h28;
      step();
      flush = 1'b0; fetch_valid = 1'b0;
      #5;
      chk("flush_count", count, 0);
      chk("flush_valid", disp_valid, 0);
      step();
      push_one(32'h100);
      #5;
      chk("after_flush_valid", disp_valid, 1);
      chk("after_flush_pc", pc_out, 32'h100);
      step();
      disp_ready = 1'b1;
      step();
      disp_ready = 1'b0;

      // empty queue, consumer ready
      fetch_valid = 1'b1; pc_in = 32'h40; instr_in = 32'h1234_5678; disp_ready = 1'b1;
`ifdef INSTR_QUEUE_BYPASS_EN
      #5;
      chk("byp_valid", disp_valid, 1);
      chk("byp_pc", pc_out, 32'h40);
      step();
      fetch_valid = 1'b0; disp_ready = 1'b0;
      #5;
      chk("byp_count", count, 0);
`else
      #5;
      chk("nobyp_valid0", disp_valid, 0);
      step();
      fetch_valid = 1'b0; disp_ready = 1'b0;
      #5;
      chk("nobyp_valid1", disp_valid, 1);
      chk("nobyp_pc", pc_out, 32'h40);
      chk("nobyp_count", count, 1);
`endif
      step();

      // randomized traffic; fetch holds its entry until the model accepts it
      for (int c = 0; c < 3000; c++) begin
         bit new_item;
         new_item = accepted || !fetch_valid;
         if (new_item) begin
            fetch_valid = ($urandom_range(0, 9) < 7);
            instr_in    = $urandom;
            pc_in       = $urandom;
         end
         disp_ready = $urandom_range(0, 1);
         flush      = ($urandom_range(0, 29) == 0);
         nrst       = ($urandom_range(0, 199) != 0);
         step();
      end
      nrst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; disp_ready = 1'b0;
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
